spi_burst_master: RTL and testbench

Parametrised SPI mode-0 master for the ACL2 (ADXL362) accelerometer path, successor to the fixed single-register SPI controller. It runs one instruction/address/data transaction per START: either a read or a write burst of 1..MAX_BURST consecutive registers. Read bytes stream out with a valid strobe; write bytes are pulled in through a request strobe. It sits between the operation/address selection logic and the Pmod pins, and feeds the display and data-capture logic.

---
 rtl/spi_burst_master.sv | 180 ++++++++++++++++++
 tb/tb_spi_burst_master.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_master.sv
// SPI mode-0 burst master for the ADXL362: one instruction/address/data frame per START,
// reading or writing 1..MAX_BURST consecutive registers.
//
// state | meaning
// IDLE  | CS high, waiting for START
// SHIFT | clocking instruction, address and data bits
// HOLD  | CS low, SCLK low, hold time after the last falling edge
// GAP   | CS high, still busy, minimum deselect time
module spi_burst_master #(
  parameter int CLK_DIV   = 63,
  parameter int MAX_BURST = 8,
  parameter int LW        = $clog2(MAX_BURST + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          RW,
  input  logic [7:0]    ADDR,
  input  logic [LW-1:0] LEN,
  input  logic [7:0]    WR_DATA,
  output logic          WR_REQ,
  output logic [7:0]    RD_DATA,
  output logic          RD_VALID,
  output logic [LW-1:0] RD_INDEX,
  output logic          BUSY,
  output logic          DONE,
  output logic          CS,
  output logic          SCLK,
  output logic          MOSI,
  input  logic          MISO
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = LW + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [LW-1:0] MAX_L    = LW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [BW-1:0] last_byte;
  logic [BW-1:0] next_byte;
  logic [BW-1:0] n_clamp;
  logic          rw_q;
  logic          rd_pend;
  logic [7:0]    addr_q;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic [7:0]    next_load;
  logic [7:0]    instr;

  always_comb begin
    n_clamp = {1'b0, LEN};
    if (LEN == '0)
      n_clamp = BW'(1);
    else if (LEN > MAX_L)
      n_clamp = {1'b0, MAX_L};
    instr     = RW ? 8'h0B : 8'h0A;
    next_byte = byte_cnt + BW'(1);
    // byte 1 is the address; data bytes carry the write byte, or zeros when reading
    if (next_byte == BW'(1))
      next_load = addr_q;
    else if (rw_q)
      next_load = 8'h00;
    else
      next_load = WR_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      last_byte <= '0;
      rw_q      <= 1'b0;
      rd_pend   <= 1'b0;
      addr_q    <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      CS        <= 1'b1;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      WR_REQ    <= 1'b0;
      RD_VALID  <= 1'b0;
      RD_DATA   <= '0;
      RD_INDEX  <= '0;
    end else begin
      DONE     <= 1'b0;
      WR_REQ   <= 1'b0;
      RD_VALID <= 1'b0;

      // publish one cycle after the 8th sample; byte_cnt is still that byte's index
      if (rd_pend) begin
        rd_pend  <= 1'b0;
        RD_VALID <= 1'b1;
        RD_DATA  <= rx_sh;
        RD_INDEX <= LW'(byte_cnt - BW'(2));
      end

      case (state)
        IDLE: begin
          if (START) begin
            rw_q      <= RW;
            addr_q    <= ADDR;
            last_byte <= n_clamp + BW'(1);
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            div_cnt   <= DIV_LAST;
            CS        <= 1'b0;
            SCLK      <= 1'b0;
            BUSY      <= 1'b1;
            MOSI      <= instr[7];
            tx_sh     <= {instr[6:0], 1'b0};
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_LAST;
            if (!SCLK) begin
              SCLK  <= 1'b1;
              rx_sh <= {rx_sh[6:0], MISO};
              if (rw_q && byte_cnt >= BW'(2) && bit_cnt == 3'd7)
                rd_pend <= 1'b1;
            end else begin
              SCLK <= 1'b0;
              if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
                MOSI    <= tx_sh[7];
                tx_sh   <= {tx_sh[6:0], 1'b0};
              end else if (byte_cnt == last_byte) begin
                state <= HOLD;
              end else begin
                byte_cnt <= next_byte;
                bit_cnt  <= '0;
                MOSI     <= next_load[7];
                tx_sh    <= {next_load[6:0], 1'b0};
                // request for data byte k goes out one byte ahead of its use
                if (!rw_q && next_byte < last_byte)
                  WR_REQ <= 1'b1;
              end
            end
          end
        end

        HOLD: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_LAST;
            CS      <= 1'b1;
            state   <= GAP;
          end
        end

        GAP: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench for spi_burst_master: a slave model and scoreboard check MOSI bytes, read strobes
// and write requests, while per-scenario tasks check counts, timing and reset behaviour.
module tb_spi_burst_master;

  localparam int C_A  = 5;
  localparam int MB_A = 8;
  localparam int LW_A = $clog2(MB_A + 1);
  localparam int C_B  = 2;
  localparam int MB_B = 4;
  localparam int LW_B = $clog2(MB_B + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start_sig = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [3:0] len = 4'd0;
  logic [7:0] wr_data = 8'h00;
  logic       miso = 1'b0;
  logic       sel = 1'b0;
  logic       start_a, start_b;

  logic            wr_req_a, rd_valid_a, busy_a, done_a, cs_a, sclk_a, mosi_a;
  logic [7:0]      rd_data_a;
  logic [LW_A-1:0] rd_index_a;
  logic            wr_req_b, rd_valid_b, busy_b, done_b, cs_b, sclk_b, mosi_b;
  logic [7:0]      rd_data_b;
  logic [LW_B-1:0] rd_index_b;

  logic       wr_req_m, rd_valid_m, busy_m, done_m, cs_m, sclk_m, mosi_m;
  logic [7:0] rd_data_m;
  logic [3:0] rd_index_m;

  assign start_a    = start_sig & ~sel;
  assign start_b    = start_sig & sel;
  assign wr_req_m   = sel ? wr_req_b   : wr_req_a;
  assign rd_valid_m = sel ? rd_valid_b : rd_valid_a;
  assign busy_m     = sel ? busy_b     : busy_a;
  assign done_m     = sel ? done_b     : done_a;
  assign cs_m       = sel ? cs_b       : cs_a;
  assign sclk_m     = sel ? sclk_b     : sclk_a;
  assign mosi_m     = sel ? mosi_b     : mosi_a;
  assign rd_data_m  = sel ? rd_data_b  : rd_data_a;
  assign rd_index_m = sel ? {1'b0, rd_index_b} : rd_index_a;

  spi_burst_master #(.CLK_DIV(C_A), .MAX_BURST(MB_A)) u_dut (
    .CLK(clk), .RST(rst), .START(start_a), .RW(rw), .ADDR(addr), .LEN(len),
    .WR_DATA(wr_data), .WR_REQ(wr_req_a), .RD_DATA(rd_data_a), .RD_VALID(rd_valid_a),
    .RD_INDEX(rd_index_a), .BUSY(busy_a), .DONE(done_a), .CS(cs_a), .SCLK(sclk_a),
    .MOSI(mosi_a), .MISO(miso)
  );

  spi_burst_master #(.CLK_DIV(C_B), .MAX_BURST(MB_B)) u_dut_c (
    .CLK(clk), .RST(rst), .START(start_b), .RW(rw), .ADDR(addr), .LEN(len[LW_B-1:0]),
    .WR_DATA(wr_data), .WR_REQ(wr_req_b), .RD_DATA(rd_data_b), .RD_VALID(rd_valid_b),
    .RD_INDEX(rd_index_b), .BUSY(busy_b), .DONE(done_b), .CS(cs_b), .SCLK(sclk_b),
    .MOSI(mosi_b), .MISO(miso)
  );

  int vectors = 0;
  int miscompares = 0;
  int n_done = 0, n_rd = 0, n_wr = 0, cs_falls = 0;
  int bitpos = 0, busy_cnt = 0, busy_len = 0;
  int run = 0, hp_min = 1000, hp_max = 0;
  int cs_high_run = 0, cs_gap = 0;

  logic [7:0]  slave_data [0:15];
  logic [7:0]  exp_mosi [$];
  logic [11:0] exp_rd [$];
  logic [7:0]  wr_src [$];

  function automatic logic slave_bit(input int p);
    int b;
    b = p / 8;
    if (b < 2 || b > 17) return 1'b0;
    return slave_data[b-2][7 - (p % 8)];
  endfunction

  function automatic int clamp_n(input int l, input int m);
    if (l == 0) return 1;
    if (l > m) return m;
    return l;
  endfunction

  // slave model + scoreboard consumer, sampling on the falling clock edge
  task automatic monitor();
    logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;
    logic [7:0] mosi_sh = 8'h00;
    logic [7:0] eb;
    logic [11:0] er;
    forever begin
      @(negedge clk);
      if (cs_m === 1'b0 && prev_cs === 1'b1) begin
        cs_falls++;
        cs_gap      = cs_high_run;
        cs_high_run = 0;
        bitpos      = 0;
        run         = 1;
        miso        = slave_bit(0);
      end else if (cs_m === 1'b0) begin
        if (sclk_m !== prev_sclk) begin
          if (run < hp_min) hp_min = run;
          if (run > hp_max) hp_max = run;
          run = 1;
          if (sclk_m === 1'b1) begin
            mosi_sh = {mosi_sh[6:0], mosi_m};
            bitpos++;
            if (bitpos % 8 == 0) begin
              vectors++;
              if (exp_mosi.size() == 0) begin
                miscompares++;
                $display("FAIL mosi_byte: got %02h, no byte expected", mosi_sh);
              end else begin
                eb = exp_mosi.pop_front();
                if (mosi_sh !== eb) begin
                  miscompares++;
                  $display("FAIL mosi_byte %0d: got %02h want %02h", bitpos / 8 - 1, mosi_sh, eb);
                end
              end
            end
          end else begin
            miso = slave_bit(bitpos);
          end
        end else begin
          run++;
        end
      end else if (cs_m === 1'b1) begin
        cs_high_run++;
      end

      if (busy_m === 1'b1) busy_cnt++;
      if (busy_m === 1'b0 && prev_busy === 1'b1) begin
        busy_len = busy_cnt;
        busy_cnt = 0;
        if (rst === 1'b0) begin
          vectors++;
          if (done_m !== 1'b1) begin
            miscompares++;
            $display("FAIL done_with_busy_fall: got DONE=%b want 1", done_m);
          end
        end
      end
      if (done_m === 1'b1) n_done++;

      if (rd_valid_m === 1'b1) begin
        n_rd++;
        vectors++;
        if (exp_rd.size() == 0) begin
          miscompares++;
          $display("FAIL rd_valid: unexpected strobe idx=%0d data=%02h", rd_index_m, rd_data_m);
        end else begin
          er = exp_rd.pop_front();
          if ({rd_index_m, rd_data_m} !== er) begin
            miscompares++;
            $display("FAIL rd_data: got idx=%0d data=%02h want idx=%0d data=%02h",
                     rd_index_m, rd_data_m, er[11:8], er[7:0]);
          end
        end
      end

      if (wr_req_m === 1'b1) begin
        n_wr++;
        vectors++;
        if (wr_src.size() == 0) begin
          miscompares++;
          $display("FAIL wr_req: got unexpected strobe, want none");
        end else begin
          wr_data = wr_src.pop_front();
        end
      end

      prev_cs   = cs_m;
      prev_sclk = sclk_m;
      prev_busy = busy_m;
    end
  endtask

  // called in the posedge+1 phase; START is sampled on the following edge
  task automatic start_txn(input logic t_rw, input logic [7:0] t_addr, input logic [3:0] t_len,
                           input int maxb);
    int n;
    n = clamp_n(int'(t_len), maxb);
    exp_mosi.push_back(t_rw ? 8'h0B : 8'h0A);
    exp_mosi.push_back(t_addr);
    for (int i = 0; i < n; i++) begin
      exp_mosi.push_back(t_rw ? 8'h00 : wr_src[i]);
      if (t_rw) exp_rd.push_back({4'(i), slave_data[i]});
    end
    start_sig = 1'b1;
    rw        = t_rw;
    addr      = t_addr;
    len       = t_len;
    @(posedge clk); #1;
    start_sig = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (n_done != d0) break;
    end
    vectors++;
    if (n_done == d0) begin
      miscompares++;
      $display("FAIL %s_timeout: got no DONE within %0d cycles, want DONE", name, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({cs_a, sclk_a, mosi_a, busy_a, done_a, wr_req_a, rd_valid_a} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 1000000",
               {cs_a, sclk_a, mosi_a, busy_a, done_a, wr_req_a, rd_valid_a});
    end
    vectors++;
    if ({rd_index_a, rd_data_a} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_rd: got idx=%0d data=%02h want 0/00", rd_index_a, rd_data_a);
    end
    vectors++;
    if ({cs_b, sclk_b, busy_b} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_dut_c: got %b want 100", {cs_b, sclk_b, busy_b});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int r0, d0, c0;
    r0 = n_rd; d0 = n_done; c0 = cs_falls;
    slave_data[0] = 8'hAD;
    start_txn(1'b1, 8'h00, 4'd1, MB_A);
    wait_done("single_read", 3000);
    vectors++;
    if (n_rd - r0 != 1) begin
      miscompares++; $display("FAIL single_read_strobes: got %0d want 1", n_rd - r0);
    end
    vectors++;
    if (n_done - d0 != 1) begin
      miscompares++; $display("FAIL single_read_done: got %0d want 1", n_done - d0);
    end
    vectors++;
    if (busy_len != 48 * C_A + 2 * C_A) begin
      miscompares++; $display("FAIL single_read_busy: got %0d want %0d", busy_len, 50 * C_A);
    end
    vectors++;
    if (cs_falls - c0 != 1 || exp_mosi.size() != 0) begin
      miscompares++;
      $display("FAIL single_read_frame: got frames=%0d left=%0d want 1/0", cs_falls - c0, exp_mosi.size());
    end
  endtask

  task automatic test_burst_read();
    int r0, c0;
    r0 = n_rd; c0 = cs_falls;
    for (int i = 0; i < 6; i++) slave_data[i] = 8'((i + 1) * 8'h11);
    start_txn(1'b1, 8'h08, 4'd6, MB_A);
    wait_done("burst_read", 5000);
    vectors++;
    if (n_rd - r0 != 6 || exp_rd.size() != 0) begin
      miscompares++;
      $display("FAIL burst_read_strobes: got %0d left=%0d want 6/0", n_rd - r0, exp_rd.size());
    end
    vectors++;
    if (cs_falls - c0 != 1) begin
      miscompares++; $display("FAIL burst_read_cs: got frames=%0d want 1", cs_falls - c0);
    end
    vectors++;
    if (busy_len != 2 * C_A * 64 + 2 * C_A) begin
      miscompares++; $display("FAIL burst_read_busy: got %0d want %0d", busy_len, 130 * C_A);
    end
  endtask

  task automatic test_write();
    int r0, w0;
    r0 = n_rd; w0 = n_wr;
    wr_src.push_back(8'h02);
    wr_src.push_back(8'h00);
    start_txn(1'b0, 8'h2D, 4'd2, MB_A);
    wait_done("write", 4000);
    vectors++;
    if (n_wr - w0 != 2 || wr_src.size() != 0) begin
      miscompares++;
      $display("FAIL write_req: got %0d left=%0d want 2/0", n_wr - w0, wr_src.size());
    end
    vectors++;
    if (n_rd - r0 != 0) begin
      miscompares++; $display("FAIL write_no_rd: got %0d want 0", n_rd - r0);
    end
    vectors++;
    if (exp_mosi.size() != 0) begin
      miscompares++; $display("FAIL write_mosi_left: got %0d want 0", exp_mosi.size());
    end
  endtask

  task automatic test_start_while_busy();
    int d0, c0;
    d0 = n_done; c0 = cs_falls;
    slave_data[0] = 8'h3C;
    start_txn(1'b1, 8'h0E, 4'd1, MB_A);
    repeat (100) @(posedge clk);
    #1;
    start_sig = 1'b1; rw = 1'b0; addr = 8'hFF; len = 4'd3;
    @(posedge clk); #1;
    start_sig = 1'b0;
    wait_done("start_busy", 3000);
    repeat (4 * C_A) @(posedge clk);
    #1;
    vectors++;
    if (n_done - d0 != 1 || cs_falls - c0 != 1) begin
      miscompares++;
      $display("FAIL start_busy_ignored: got done=%0d frames=%0d want 1/1", n_done - d0, cs_falls - c0);
    end
  endtask

  task automatic test_back_to_back();
    int d0, r0;
    bit seen;
    d0 = n_done; r0 = n_rd; seen = 0;
    slave_data[0] = 8'hC3;
    start_txn(1'b1, 8'h20, 4'd1, MB_A);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done_m === 1'b1) begin seen = 1; break; end
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL b2b_timeout: got no DONE, want DONE");
    end
    start_txn(1'b1, 8'h21, 4'd1, MB_A);
    wait_done("b2b_second", 3000);
    vectors++;
    if (n_done - d0 != 2 || n_rd - r0 != 2) begin
      miscompares++;
      $display("FAIL b2b_count: got done=%0d rd=%0d want 2/2", n_done - d0, n_rd - r0);
    end
    vectors++;
    if (cs_gap != C_A + 1) begin
      miscompares++; $display("FAIL b2b_cs_gap: got %0d want %0d", cs_gap, C_A + 1);
    end
  endtask

  task automatic test_reset_mid_burst();
    int d0, r0;
    d0 = n_done;
    for (int i = 0; i < 4; i++) slave_data[i] = 8'hA0 + 8'(i);
    start_txn(1'b1, 8'h0A, 4'd4, MB_A);
    for (int i = 0; i < 4000 && bitpos < 28; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({cs_a, sclk_a, busy_a, done_a, rd_valid_a} !== 5'b10000) begin
      miscompares++;
      $display("FAIL rst_mid: got %b want 10000", {cs_a, sclk_a, busy_a, done_a, rd_valid_a});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_mosi.delete();
    exp_rd.delete();
    repeat (50) @(posedge clk);
    #1;
    vectors++;
    if (n_done != d0) begin
      miscompares++; $display("FAIL rst_mid_no_done: got %0d want 0", n_done - d0);
    end
    r0 = n_rd;
    slave_data[0] = 8'h5A;
    start_txn(1'b1, 8'h00, 4'd1, MB_A);
    wait_done("rst_recover", 3000);
    vectors++;
    if (n_rd - r0 != 1 || busy_len != 50 * C_A) begin
      miscompares++;
      $display("FAIL rst_recover: got rd=%0d busy=%0d want 1/%0d", n_rd - r0, busy_len, 50 * C_A);
    end
  endtask

  task automatic test_clamp_timing();
    int r0;
    sel = 1'b1;
    @(posedge clk); #1;
    hp_min = 1000; hp_max = 0;
    r0 = n_rd;
    slave_data[0] = 8'h77;
    start_txn(1'b1, 8'h10, 4'd0, MB_B);
    wait_done("clamp_len0", 1000);
    vectors++;
    if (busy_len != 100 || n_rd - r0 != 1) begin
      miscompares++;
      $display("FAIL clamp_len0: got busy=%0d rd=%0d want 100/1", busy_len, n_rd - r0);
    end
    r0 = n_rd;
    for (int i = 0; i < 4; i++) slave_data[i] = 8'h81 + 8'(i);
    start_txn(1'b1, 8'h00, 4'd7, MB_B);
    wait_done("clamp_len7", 1000);
    vectors++;
    if (n_rd - r0 != 4 || exp_rd.size() != 0) begin
      miscompares++;
      $display("FAIL clamp_len7: got rd=%0d left=%0d want 4/0", n_rd - r0, exp_rd.size());
    end
    vectors++;
    if (busy_len != 2 * C_B * 48 + 2 * C_B) begin
      miscompares++; $display("FAIL clamp_len7_busy: got %0d want %0d", busy_len, 196);
    end
    vectors++;
    if (hp_min != C_B || hp_max != C_B) begin
      miscompares++;
      $display("FAIL sclk_half_period: got min=%0d max=%0d want %0d", hp_min, hp_max, C_B);
    end
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) slave_data[i] = 8'h00;
    fork
      monitor();
    join_none
    test_reset();
    test_single_read();
    test_burst_read();
    test_write();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_burst();
    test_clamp_timing();
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
